// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_issue decode/issue controller.
// Holds ALU op codes, instruction opcodes, instruction field positions,
// the $rstatus overflow codes, the controller state enum and an
// immediate sign-extension helper.
package alu_pkg;

  // ALU operations understood by the combinational ALU
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;

  // Instruction opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int SH_MSB  = 11;
  localparam int SH_LSB  = 7;
  localparam int FN_MSB  = 6;
  localparam int FN_LSB  = 2;
  localparam int IMM_MSB = 16;
  localparam int IMM_LSB = 0;

  // Value written to $rstatus on overflow; NONE means overflow is ignored
  localparam logic [1:0] OVF_NONE = 2'd0;
  localparam logic [1:0] OVF_ADD  = 2'd1;
  localparam logic [1:0] OVF_ADDI = 2'd2;
  localparam logic [1:0] OVF_SUB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic [31:0] sext_imm(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational instruction decoder.
// Ports:
//   instr            in  32  instruction word
//   rf_addr_a/b      out 5   register-file read addresses
//   rd               out 5   destination register field
//   use_imm          out 1   operand B comes from the immediate
//   imm_sext         out 32  sign-extended 17-bit immediate
//   alu_op, shamt    out 5   ALU controls
//   is_branch/is_blt out 1   branch kind
//   illegal          out 1   unsupported opcode or R-type ALU op
//   ovf_code         out 2   $rstatus code on overflow (OVF_NONE = ignore)
module instr_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  output logic [4:0]  rd,
  output logic        use_imm,
  output logic [31:0] imm_sext,
  output logic [4:0]  alu_op,
  output logic [4:0]  shamt,
  output logic        is_branch,
  output logic        is_blt,
  output logic        illegal,
  output logic [1:0]  ovf_code
);

  logic [4:0] opc_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] fn_s;
  logic       unused_s;

  assign opc_s    = instr[OPC_MSB:OPC_LSB];
  assign rs_s     = instr[RS_MSB:RS_LSB];
  assign rt_s     = instr[RT_MSB:RT_LSB];
  assign fn_s     = instr[FN_MSB:FN_LSB];
  assign unused_s = ^instr[1:0];

  // Field extraction and per-opcode operand/op selection
  always_comb begin
    rd        = instr[RD_MSB:RD_LSB];
    shamt     = instr[SH_MSB:SH_LSB];
    imm_sext  = sext_imm(instr[IMM_MSB:IMM_LSB]);
    rf_addr_a = rs_s;
    rf_addr_b = rt_s;
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    is_blt    = 1'b0;
    illegal   = 1'b0;
    ovf_code  = OVF_NONE;
    case (opc_s)
      OP_RTYPE: begin
        if (fn_s <= ALU_SRA) begin
          alu_op = fn_s;
          if (fn_s == ALU_ADD) begin
            ovf_code = OVF_ADD;
          end else if (fn_s == ALU_SUB) begin
            ovf_code = OVF_SUB;
          end else begin
            ovf_code = OVF_NONE;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        use_imm  = 1'b1;
        ovf_code = OVF_ADDI;
      end
      OP_BNE, OP_BLT: begin
        // Branches compare $rd against $rs, so rd is read on port A
        rf_addr_a = instr[RD_MSB:RD_LSB];
        rf_addr_b = rs_s;
        alu_op    = ALU_SUB;
        is_branch = 1'b1;
        is_blt    = (opc_s == OP_BLT);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue controller for the combinational ALU.
// One instruction in flight: IDLE (accept) -> READ (RF data returns)
// -> EXEC (ALU driven from registered operands) -> RESP (result held).
// Ports:
//   clock, reset                   clock, synchronous active-high reset
//   in_valid/in_ready/in_instr     instruction handshake
//   rf_addr_a/b, rf_data_a/b       register-file read (data one cycle later)
//   alu_a/b, alu_op, alu_shamt     registered ALU operands and controls
//   alu_result/ne/gt/ovf           ALU outputs
//   res_valid/res_ready            result handshake
//   res_we/rd/data                 register write request
//   res_branch/taken/offset        branch outcome
//   res_illegal                    unsupported instruction
module alu_issue
  import alu_pkg::*;
#(
  parameter logic [4:0] RSTATUS_REG = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_gt,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_we,
  output logic [4:0]  res_rd,
  output logic [31:0] res_data,
  output logic        res_branch,
  output logic        res_taken,
  output logic [31:0] res_offset,
  output logic        res_illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        in_ready_q, in_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]  alu_op_q, alu_op_d, alu_shamt_q, alu_shamt_d;
  logic        res_we_q, res_we_d, res_branch_q, res_branch_d;
  logic        res_taken_q, res_taken_d, res_illegal_q, res_illegal_d;
  logic [4:0]  res_rd_q, res_rd_d;
  logic [31:0] res_data_q, res_data_d, res_offset_q, res_offset_d;

  logic [31:0] dec_instr_s;
  logic [4:0]  dec_addr_a_s, dec_addr_b_s, dec_rd_s, dec_op_s, dec_shamt_s;
  logic        dec_use_imm_s, dec_branch_s, dec_blt_s, dec_illegal_s;
  logic [31:0] dec_imm_s;
  logic [1:0]  dec_ovf_s;

  // In IDLE the offered instruction is decoded so the RF read starts in the
  // acceptance cycle; afterwards the latched copy is decoded.
  assign dec_instr_s = (state_q == ST_IDLE) ? in_instr : instr_q;

  instr_decode u_dec (
    .instr     (dec_instr_s),
    .rf_addr_a (dec_addr_a_s),
    .rf_addr_b (dec_addr_b_s),
    .rd        (dec_rd_s),
    .use_imm   (dec_use_imm_s),
    .imm_sext  (dec_imm_s),
    .alu_op    (dec_op_s),
    .shamt     (dec_shamt_s),
    .is_branch (dec_branch_s),
    .is_blt    (dec_blt_s),
    .illegal   (dec_illegal_s),
    .ovf_code  (dec_ovf_s)
  );

  // Read addresses stay at zero while nothing is offered in IDLE
  assign rf_addr_a = ((state_q == ST_IDLE) && !in_valid) ? 5'd0 : dec_addr_a_s;
  assign rf_addr_b = ((state_q == ST_IDLE) && !in_valid) ? 5'd0 : dec_addr_b_s;

  assign in_ready    = in_ready_q;
  assign res_valid   = res_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_shamt   = alu_shamt_q;
  assign res_we      = res_we_q;
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;
  assign res_branch  = res_branch_q;
  assign res_taken   = res_taken_q;
  assign res_offset  = res_offset_q;
  assign res_illegal = res_illegal_q;

  // Next-state, operand capture and result formation
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_shamt_d   = alu_shamt_q;
    res_we_d      = res_we_q;
    res_rd_d      = res_rd_q;
    res_data_d    = res_data_q;
    res_branch_d  = res_branch_q;
    res_taken_d   = res_taken_q;
    res_offset_d  = res_offset_q;
    res_illegal_d = res_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        alu_a_d     = rf_data_a;
        alu_b_d     = dec_use_imm_s ? dec_imm_s : rf_data_b;
        alu_op_d    = dec_op_s;
        alu_shamt_d = dec_shamt_s;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        res_we_d      = 1'b0;
        res_rd_d      = 5'd0;
        res_data_d    = 32'd0;
        res_branch_d  = 1'b0;
        res_taken_d   = 1'b0;
        res_offset_d  = 32'd0;
        res_illegal_d = dec_illegal_s;
        if (dec_illegal_s) begin
          res_we_d = 1'b0;
        end else if (dec_branch_s) begin
          // blt: A < B signed  <=>  A != B and not A > B
          res_branch_d = 1'b1;
          res_taken_d  = dec_blt_s ? (alu_ne & ~alu_gt) : alu_ne;
          res_offset_d = dec_imm_s;
        end else if ((dec_ovf_s != OVF_NONE) && alu_ovf) begin
          res_we_d   = 1'b1;
          res_rd_d   = RSTATUS_REG;
          res_data_d = {30'd0, dec_ovf_s};
        end else begin
          res_we_d   = 1'b1;
          res_rd_d   = dec_rd_s;
          res_data_d = alu_result;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
  end

  // State, operand and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= 32'd0;
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_op_q      <= 5'd0;
      alu_shamt_q   <= 5'd0;
      res_we_q      <= 1'b0;
      res_rd_q      <= 5'd0;
      res_data_q    <= 32'd0;
      res_branch_q  <= 1'b0;
      res_taken_q   <= 1'b0;
      res_offset_q  <= 32'd0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_shamt_q   <= alu_shamt_d;
      res_we_q      <= res_we_d;
      res_rd_q      <= res_rd_d;
      res_data_q    <= res_data_d;
      res_branch_q  <= res_branch_d;
      res_taken_q   <= res_taken_d;
      res_offset_q  <= res_offset_d;
      res_illegal_q <= res_illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue. Provides a register-file
// model with one-cycle read latency and a behavioural ALU; expected results
// come from a hand-written vector table and from an instruction-level
// reference model used for randomized stimulus.
module tb_alu_issue;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        branch;
    logic        taken;
    logic [31:0] offset;
    logic        illegal;
    logic        chk_alub;
    logic [31:0] alub;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    int          ia;
    logic [31:0] va;
    int          ib;
    logic [31:0] vb;
    exp_t        e;
  } vec_t;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op, alu_shamt;
  logic        alu_ne, alu_gt, alu_ovf;
  logic        res_valid, res_ready, res_we, res_branch, res_taken, res_illegal;
  logic [4:0]  res_rd;
  logic [31:0] res_data, res_offset;

  logic [31:0] regs [32];
  longint      alu_s;
  int          n_total = 0;
  int          n_pass  = 0;
  vec_t        tbl [18];

  alu_issue #(.RSTATUS_REG(5'd30)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_gt(alu_gt), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_we(res_we), .res_rd(res_rd), .res_data(res_data),
    .res_branch(res_branch), .res_taken(res_taken), .res_offset(res_offset),
    .res_illegal(res_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: read data valid one cycle after the address
  always @(posedge clock) begin
    rf_data_a <= regs[rf_addr_a];
    rf_data_b <= regs[rf_addr_b];
  end

  // Behavioural ALU
  always_comb begin
    alu_s      = 64'sd0;
    alu_result = 32'd0;
    alu_ovf    = 1'b0;
    alu_ne     = (alu_a != alu_b);
    alu_gt     = ($signed(alu_a) > $signed(alu_b));
    case (alu_op)
      5'd0: begin
        alu_s      = longint'($signed(alu_a)) + longint'($signed(alu_b));
        alu_result = alu_s[31:0];
        alu_ovf    = (alu_s > MAXI) || (alu_s < MINI);
      end
      5'd1: begin
        alu_s      = longint'($signed(alu_a)) - longint'($signed(alu_b));
        alu_result = alu_s[31:0];
        alu_ovf    = (alu_s > MAXI) || (alu_s < MINI);
      end
      5'd2: alu_result = alu_a & alu_b;
      5'd3: alu_result = alu_a | alu_b;
      5'd4: alu_result = alu_a << alu_shamt;
      5'd5: alu_result = $signed(alu_a) >>> alu_shamt;
      default: alu_result = 32'd0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.we = 1'b0; e.rd = 5'd0; e.data = 32'd0; e.branch = 1'b0; e.taken = 1'b0;
    e.offset = 32'd0; e.illegal = 1'b0; e.chk_alub = 1'b0; e.alub = 32'd0;
    return e;
  endfunction

  function automatic exp_t ew(input logic [4:0] rd, input logic [31:0] d);
    exp_t e = blank();
    e.we = 1'b1; e.rd = rd; e.data = d;
    return e;
  endfunction

  function automatic exp_t eb(input logic taken, input logic [31:0] off);
    exp_t e = blank();
    e.branch = 1'b1; e.taken = taken; e.offset = off;
    return e;
  endfunction

  function automatic exp_t eill();
    exp_t e = blank();
    e.illegal = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] mkr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] fn);
    return {op, rd, rs, rt, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] mki(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Arithmetic write: an out-of-range signed sum becomes a $rstatus write
  function automatic exp_t arith(input logic [4:0] rd, input longint s, input logic [31:0] code);
    if (s > MAXI || s < MINI) return ew(5'd30, code);
    return ew(rd, s[31:0]);
  endfunction

  // Instruction-level reference model
  function automatic exp_t model(input logic [31:0] instr);
    logic [4:0]  op, rd, rs, rt, sh, fn;
    logic [31:0] a, b, imm;
    op = instr[31:27]; rd = instr[26:22]; rs = instr[21:17];
    rt = instr[16:12]; sh = instr[11:7];  fn = instr[6:2];
    imm = {{15{instr[16]}}, instr[16:0]};
    a = regs[rs];
    b = regs[rt];
    if (op == 5'b00000) begin
      case (fn)
        5'd0: return arith(rd, longint'($signed(a)) + longint'($signed(b)), 32'd1);
        5'd1: return arith(rd, longint'($signed(a)) - longint'($signed(b)), 32'd3);
        5'd2: return ew(rd, a & b);
        5'd3: return ew(rd, a | b);
        5'd4: return ew(rd, a << sh);
        5'd5: return ew(rd, $signed(a) >>> sh);
        default: return eill();
      endcase
    end else if (op == 5'b00101) begin
      return arith(rd, longint'($signed(a)) + longint'($signed(imm)), 32'd2);
    end else if (op == 5'b00010) begin
      return eb(regs[rd] != regs[rs], imm);
    end else if (op == 5'b00110) begin
      return eb($signed(regs[rd]) < $signed(regs[rs]), imm);
    end
    return eill();
  endfunction

  task automatic accept(input logic [31:0] instr);
    int w = 0;
    while (!in_ready && w < 10) begin
      @(posedge clock); @(negedge clock); w++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    in_instr = $urandom();
  endtask

  task automatic check_res(input string tag, input exp_t e);
    chk({tag, "_valid"},   {31'd0, res_valid},   32'd1);
    chk({tag, "_illegal"}, {31'd0, res_illegal}, {31'd0, e.illegal});
    chk({tag, "_we"},      {31'd0, res_we},      {31'd0, e.we});
    chk({tag, "_branch"},  {31'd0, res_branch},  {31'd0, e.branch});
    if (e.we) begin
      chk({tag, "_rd"},   {27'd0, res_rd}, {27'd0, e.rd});
      chk({tag, "_data"}, res_data, e.data);
    end
    if (e.branch) begin
      chk({tag, "_taken"},  {31'd0, res_taken}, {31'd0, e.taken});
      chk({tag, "_offset"}, res_offset, e.offset);
    end
  endtask

  // Issue one instruction, check latency and result, optionally stall res_ready
  task automatic issue_check(input string tag, input logic [31:0] instr, input exp_t e, input int hold);
    int k;
    res_ready = (hold == 0) ? 1'b1 : 1'b0;
    accept(instr);
    chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    @(posedge clock); @(negedge clock);
    if (e.chk_alub) chk({tag, "_alu_b_exec"}, alu_b, e.alub);
    k = 2;
    while (!res_valid && k < 12) begin
      @(posedge clock); @(negedge clock); k++;
    end
    chk({tag, "_latency"}, k, 32'd3);
    if (res_valid) check_res(tag, e);
    for (int h = 1; h <= hold; h++) begin
      @(posedge clock); @(negedge clock);
      check_res({tag, "_hold"}, e);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    chk({tag, "_after_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_after_hs_valid"},    {31'd0, res_valid}, 32'd0);
  endtask

  task automatic set_vec(input int i, input logic [31:0] instr, input int ia, input logic [31:0] va,
                         input int ib, input logic [31:0] vb, input exp_t e);
    tbl[i].instr = instr; tbl[i].ia = ia; tbl[i].va = va;
    tbl[i].ib = ib; tbl[i].vb = vb; tbl[i].e = e;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    chk({tag, "_valid"},    {31'd0, res_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready},  32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); @(negedge clock);
      chk({tag, "_no_result"}, {31'd0, res_valid}, 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] instr;
    logic [4:0]  op;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; res_ready = 1'b1;

    // Vector table: instruction, operand registers and expected outcome
    set_vec(0,  mkr(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0), 1, 32'h7FFFFFFF, 2, 32'h1, ew(5'd30, 32'd1));
    e = ew(5'd4, 32'd4); e.chk_alub = 1'b1; e.alub = 32'hFFFFFFFF;
    set_vec(1,  mki(5'b00101, 5'd4, 5'd5, 17'h1FFFF), 5, 32'd5, 6, 32'd0, e);
    set_vec(2,  mki(5'b00110, 5'd6, 5'd7, 17'h00010), 6, 32'hFFFFFFFD, 7, 32'd2, eb(1'b1, 32'd16));
    set_vec(3,  mki(5'b00010, 5'd8, 5'd9, 17'h1FFF0), 8, 32'd5, 9, 32'd5, eb(1'b0, 32'hFFFFFFF0));
    set_vec(4,  mkr(5'd0, 5'd10, 5'd11, 5'd12, 5'd0, 5'd1), 11, 32'h80000000, 12, 32'd1, ew(5'd30, 32'd3));
    set_vec(5,  mkr(5'b11111, 5'd13, 5'd14, 5'd15, 5'd0, 5'd0), 14, 32'd1, 15, 32'd2, eill());
    set_vec(6,  mkr(5'd0, 5'd13, 5'd14, 5'd15, 5'd0, 5'd6), 14, 32'd1, 15, 32'd2, eill());
    set_vec(7,  mkr(5'd0, 5'd16, 5'd17, 5'd18, 5'd0, 5'd2), 17, 32'hF0F01234, 18, 32'h0FF0FF00, ew(5'd16, 32'h00F01200));
    set_vec(8,  mkr(5'd0, 5'd16, 5'd17, 5'd18, 5'd0, 5'd3), 17, 32'hF0F01234, 18, 32'h0FF0FF00, ew(5'd16, 32'hFFF0FF34));
    set_vec(9,  mkr(5'd0, 5'd16, 5'd17, 5'd18, 5'd4, 5'd4), 17, 32'h12345678, 18, 32'd0, ew(5'd16, 32'h23456780));
    set_vec(10, mkr(5'd0, 5'd16, 5'd17, 5'd18, 5'd8, 5'd5), 17, 32'h80001200, 18, 32'd0, ew(5'd16, 32'hFF800012));
    set_vec(11, mkr(5'd0, 5'd0, 5'd19, 5'd20, 5'd0, 5'd0), 19, 32'hFFFFFFFF, 20, 32'd1, ew(5'd0, 32'd0));
    set_vec(12, mkr(5'd0, 5'd23, 5'd21, 5'd22, 5'd0, 5'd0), 21, 32'h80000000, 22, 32'hFFFFFFFF, ew(5'd30, 32'd1));
    set_vec(13, mki(5'b00010, 5'd24, 5'd25, 17'h00004), 24, 32'd1, 25, 32'd2, eb(1'b1, 32'd4));
    set_vec(14, mki(5'b00110, 5'd26, 5'd27, 17'h1FFFF), 26, 32'd7, 27, 32'd7, eb(1'b0, 32'hFFFFFFFF));
    set_vec(15, mki(5'b00110, 5'd28, 5'd29, 17'h00008), 28, 32'd5, 29, 32'hFFFFFFFF, eb(1'b0, 32'd8));
    set_vec(16, mki(5'b00101, 5'd2, 5'd31, 17'h00001), 31, 32'h7FFFFFFF, 3, 32'd0, ew(5'd30, 32'd2));
    set_vec(17, mkr(5'd0, 5'd5, 5'd1, 5'd2, 5'd0, 5'd1), 1, 32'd10, 2, 32'd3, ew(5'd5, 32'd7));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_flags",     {27'd0, res_valid, res_we, res_branch, res_taken, res_illegal}, 32'd0);
    chk("rst_res_rd",    {27'd0, res_rd}, 32'd0);
    chk("rst_res_data",  res_data, 32'd0);
    chk("rst_res_off",   res_offset, 32'd0);
    chk("rst_alu_ab",    alu_a | alu_b, 32'd0);
    chk("rst_alu_ctl",   {22'd0, alu_op, alu_shamt}, 32'd0);
    chk("rst_rf_addr",   {22'd0, rf_addr_a, rf_addr_b}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      regs[tbl[i].ia] = tbl[i].va;
      regs[tbl[i].ib] = tbl[i].vb;
      issue_check($sformatf("vec%0d", i), tbl[i].instr, tbl[i].e, 0);
    end

    // Backpressure: result held for 5 cycles with res_ready low
    regs[1] = 32'h7FFFFFFF; regs[2] = 32'd1;
    issue_check("hold5", tbl[0].instr, tbl[0].e, 5);

    // Reset during EXEC drops the instruction
    res_ready = 1'b1;
    accept(tbl[17].instr);
    @(posedge clock); @(negedge clock);
    pulse_reset_and_check("rst_exec");

    // Reset during RESP with res_valid high drops the result
    res_ready = 1'b0;
    accept(tbl[17].instr);
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    chk("rst_resp_pre_valid", {31'd0, res_valid}, 32'd1);
    pulse_reset_and_check("rst_resp");
    res_ready = 1'b1;

    // Normal operation resumes after reset
    regs[1] = 32'd10; regs[2] = 32'd3;
    issue_check("post_rst", tbl[17].instr, tbl[17].e, 0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      if (n % 16 == 0) begin
        for (int r = 1; r < 32; r++) begin
          case ($urandom_range(0, 5))
            0: regs[r] = 32'h7FFFFFFF;
            1: regs[r] = 32'h80000000;
            2: regs[r] = 32'hFFFFFFFF;
            3: regs[r] = 32'd0;
            4: regs[r] = 32'd1;
            default: regs[r] = $urandom();
          endcase
        end
      end
      instr = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 5'b00000;
        4, 5:       op = 5'b00101;
        6:          op = 5'b00010;
        7:          op = 5'b00110;
        default:    op = 5'($urandom_range(0, 31));
      endcase
      instr[31:27] = op;
      if (op == 5'b00000) instr[6:2] = 5'($urandom_range(0, 7));
      issue_check($sformatf("rnd%0d", n), instr, model(instr), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue controller that drives the processor's combinational ALU. It accepts one 32-bit instruction at a time over a valid/ready handshake and fetches operands from the register file. It presents opcode, shift amount and operands to the ALU, captures the ALU's result and flags, and emits one writeback/branch record per instruction. Overflow on add, addi and sub is converted to a write of `$rstatus` (register 30).

## Interface
Parameters:
- `RSTATUS_REG`, 30: register index written on arithmetic overflow.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1, `in_ready` out 1, `in_instr` in 32: instruction handshake.
- `rf_addr_a` out 5, `rf_addr_b` out 5: register-file read addresses.
- `rf_data_a` in 32, `rf_data_b` in 32: read data, valid one cycle after the address.
- `alu_a` out 32, `alu_b` out 32, `alu_op` out 5, `alu_shamt` out 5: ALU operands and controls.
- `alu_result` in 32, `alu_ne` in 1, `alu_gt` in 1, `alu_ovf` in 1: ALU outputs. `alu_gt` is the signed comparison A > B.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_we` out 1, `res_rd` out 5, `res_data` out 32: register write request.
- `res_branch` out 1, `res_taken` out 1, `res_offset` out 32: branch outcome and sign-extended offset.
- `res_illegal` out 1: unsupported opcode or ALU op.

## Operation
- Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], imm [16:0]. The immediate is sign-extended from bit 16.
- R-type (opcode 00000): A = $rs, B = $rt.
  - aluop 00000–00101 (add, sub, and, or, sll, sra) is passed through to the ALU.
  - Any other aluop is illegal.
- addi (00101): A = $rs, B = sext(imm), alu_op = add.
- bne (00010) and blt (00110): A = $rd, B = $rs, alu_op = sub, res_branch = 1, res_we = 0.
  - bne taken = alu_ne.
  - blt taken = alu_ne & ~alu_gt.
  - res_offset = sext(imm).
- Any other opcode: res_illegal = 1, res_we = 0, res_branch = 0.
- Overflow (alu_ovf = 1) on add, addi or sub: res_rd = RSTATUS_REG, res_we = 1, and res_data = 1, 2 or 3 respectively. Overflow is ignored for all other operations.
- Normal writes: res_rd = rd, res_data = alu_result, res_we = 1.
  - Writes to rd = 0 are still reported; the register file discards them.
- State machine:
  - IDLE: in_ready = 1. On in_valid, latch the instruction, drive rf_addr_a/b, go to READ.
  - READ: the register file returns data. Go to EXEC.
  - EXEC: drive the ALU from registered operands. At the clock edge, capture result and flags into the result register. Go to RESP.
  - RESP: res_valid = 1. On res_ready, go to IDLE.
- rf_addr_a/b are driven from the latched instruction in READ (from the input instruction in IDLE).
  - R-type/addi: rf_addr_a = rs, rf_addr_b = rt.
  - Branches: rf_addr_a = rd, rf_addr_b = rs.
- Illegal instructions still traverse READ and EXEC. This keeps latency constant.

## Timing
- One instruction in flight. Acceptance to res_valid is 3 cycles (accept in cycle 0, res_valid high in cycle 3). Throughput is one instruction per 4 cycles with res_ready held high.
- in_ready is high only in IDLE. It is never high while res_valid is high.
- res_* fields stay stable while res_valid = 1 and res_ready = 0.
- alu_* outputs are registered and stable throughout EXEC. Outside EXEC they hold their last value.
- Reset:
  - State goes to IDLE.
  - in_ready = 1 in the cycle after reset deasserts.
  - res_valid, res_we, res_branch, res_taken and res_illegal = 0.
  - res_rd = 0, res_data = 0, res_offset = 0.
  - alu_a, alu_b, alu_op and alu_shamt = 0; rf_addr_a/b = 0.
- Reset asserted in any state, including RESP with res_valid high, drops the in-flight instruction with no result emitted.
- in_valid while not in IDLE is ignored; the instruction must be held by the sender.

## Structure
- Shared package `alu_pkg`:
  - ALU op constants: ADD = 0, SUB = 1, AND = 2, OR = 3, SLL = 4, SRA = 5.
  - Instruction opcodes: RTYPE, ADDI, BNE, BLT.
  - Field bit positions.
  - rstatus codes 1, 2, 3.
  - FSM state enum.
- Natural sub-module: `instr_decode`, a purely combinational block. It takes the instruction and produces:
  - operand selects and register addresses;
  - alu_op and shamt;
  - is_branch, is_blt, illegal and the overflow code.
- `alu_issue` holds the FSM, the operand/result registers and the handshake.

## Test plan
- add, $1 = 0x7FFFFFFF, $2 = 1 -> res_we = 1, res_rd = 30, res_data = 1, 3 cycles after acceptance.
- addi rd = 4, $rs = 5, imm = 0x1FFFF -> alu_b = 0xFFFFFFFF, res_rd = 4, res_data = 4, no overflow.
- blt with $rd = -3, $rs = 2, imm = 0x00010 -> res_branch = 1, res_taken = 1, res_offset = 16, res_we = 0.
- bne with equal operands -> res_taken = 0. sub of 0x80000000 - 1 -> res_rd = 30, res_data = 3.
- Hold res_ready = 0 for 5 cycles -> res_* stable and in_ready = 0 throughout. Then accept; the next in_valid is taken in the cycle after the handshake.
- Assert reset in EXEC, and separately in RESP -> next cycle res_valid = 0 and in_ready = 1. Illegal opcode 11111 -> res_illegal = 1, res_we = 0.
